// File: rtl/turbo_half_iter_scheduler.sv
// Half-iteration sequencer for a turbo decoder sharing one BCJR engine between
// decoder 0 (natural order) and decoder 1 (interleaved order).
module turbo_half_iter_scheduler #(
  parameter int MAX_ITER = 4,
  parameter int ITER_W   = 3,
  parameter int TIMEOUT  = 64,
  parameter int TO_W     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_req,
  input  logic              abort,
  output logic              bcjr_in_valid,
  input  logic              bcjr_out_valid,
  output logic              dec_sel,
  output logic              use_apriori,
  output logic              ext_wr_en,
  output logic [ITER_W:0]   half_cnt,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t            state;
  logic [ITER_W-1:0] n_iter;
  logic [ITER_W-1:0] req_clamp;
  logic [ITER_W:0]   last_half;
  logic [TO_W-1:0]   wd;

  // A request of zero still runs one full iteration.
  always_comb begin
    req_clamp = iter_req;
    if (iter_req == '0)
      req_clamp = ITER_W'(1);
    else if (iter_req > ITER_W'(MAX_ITER))
      req_clamp = ITER_W'(MAX_ITER);
  end

  assign last_half   = {n_iter, 1'b0} - (ITER_W+1)'(1);
  assign use_apriori = (half_cnt != '0);
  assign ext_wr_en   = bcjr_out_valid && (state == S_WAIT);

  // bcjr_in_valid, done and busy are flopped together with the state so they
  // track it exactly without decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      n_iter        <= '0;
      wd            <= '0;
      half_cnt      <= '0;
      dec_sel       <= 1'b0;
      timeout_err   <= 1'b0;
      bcjr_in_valid <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      bcjr_in_valid <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            n_iter        <= req_clamp;
            half_cnt      <= '0;
            dec_sel       <= 1'b0;
            timeout_err   <= 1'b0;
            bcjr_in_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
          S_ISSUE: begin
            wd    <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (bcjr_out_valid) begin
              if (half_cnt == last_half) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= S_NEXT;
              end
            end else if (wd == TO_W'(TIMEOUT-1)) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= S_IDLE;
            end else begin
              wd <= wd + TO_W'(1);
            end
          end
          S_NEXT: begin
            half_cnt      <= half_cnt + (ITER_W+1)'(1);
            dec_sel       <= ~dec_sel;
            bcjr_in_valid <= 1'b1;
            state         <= S_ISSUE;
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
